// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for a 4-lane uint8 x int8 MAC with a 32-bit accumulator.
// Feeds masked operand beats, holds lanes at zero when idle, returns the final sum.
module mac_seq_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [31:0]      op_act,
  input  logic [31:0]      op_wgt,
  output logic             mac_clr_n,
  output logic [31:0]      mac_act,
  output logic [31:0]      mac_wgt,
  input  logic [31:0]      mac_acc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    RESULT
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] beats_left;
  logic [1:0]       tail;
  logic             clr_q;
  logic [31:0]      res_q;
  logic [LEN_W:0]   len_up;
  logic             op_fire;
  logic             last;

  assign len_up    = {1'b0, cmd_len} + (LEN_W+1)'(3);
  assign op_fire   = op_valid && (state == RUN) && !reset;
  assign last      = (beats_left == LEN_W'(1));

  assign cmd_ready = (state == IDLE);
  assign op_ready  = (state == RUN);
  assign res_valid = (state == RESULT);
  assign busy      = (state != IDLE);
  assign mac_clr_n = clr_q;
  assign res_data  = res_q;

  // Lanes are zero unless a beat is accepted; tail lanes of the last beat are masked.
  always_comb begin
    mac_act = '0;
    mac_wgt = '0;
    if (op_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (!(last && tail != 2'd0 && 3'(i) >= {1'b0, tail})) begin
          mac_act[8*i +: 8] = op_act[8*i +: 8];
          mac_wgt[8*i +: 8] = op_wgt[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      beats_left <= '0;
      tail       <= '0;
      clr_q      <= 1'b0;
      res_q      <= '0;
    end else begin
      clr_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            beats_left <= {1'b0, len_up[LEN_W:2]};
            tail       <= cmd_len[1:0];
            clr_q      <= 1'b0;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          state <= (beats_left != '0) ? RUN : DRAIN;
        end
        RUN: begin
          if (op_fire) begin
            beats_left <= beats_left - LEN_W'(1);
            if (last) state <= DRAIN;
          end
        end
        DRAIN: begin
          res_q <= mac_acc;
          state <= RESULT;
        end
        RESULT: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural 4-lane MAC attached.
// Each scenario task drives its own stimulus and checks against hand-computed values.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_act;
  logic [31:0] op_wgt;
  logic        mac_clr_n;
  logic [31:0] mac_act;
  logic [31:0] mac_wgt;
  logic [31:0] mac_acc;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  mac_seq_ctrl #(.LEN_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_act    (op_act),
    .op_wgt    (op_wgt),
    .mac_clr_n (mac_clr_n),
    .mac_act   (mac_act),
    .mac_wgt   (mac_wgt),
    .mac_acc   (mac_acc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 4; i++)
      s = s + 32'($signed({1'b0, a[8*i +: 8]}) * $signed(w[8*i +: 8]));
    return s;
  endfunction

  // Behavioural MAC: registered accumulator, active-low clear
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mac_clr_n) mac_acc <= '0;
    else            mac_acc <= mac_acc + dot4(mac_act, mac_wgt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [15:0] len, output int c);
    cmd_valid = 1'b1;
    cmd_len   = len;
    c = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (cmd_ready) c = cyc;
      tick();
      if (c >= 0) break;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] w, output int t,
                      output logic [31:0] ma, output logic [31:0] mw);
    op_valid = 1'b1;
    op_act   = a;
    op_wgt   = w;
    t  = -1;
    ma = 'x;
    mw = 'x;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (op_ready) begin
        t  = cyc;
        ma = mac_act;
        mw = mac_wgt;
      end
      tick();
      if (t >= 0) break;
    end
    op_valid = 1'b0;
    op_act   = 32'hDEAD_BEEF;
    op_wgt   = 32'h8181_8181;
  endtask

  task automatic wait_res(output int r);
    r = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (res_valid) begin
        r = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    op_valid  = 1'b1;
    op_act    = 32'hFFFF_FFFF;
    op_wgt    = 32'h7F7F_7F7F;
    res_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || op_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl got rdy=%b op=%b rv=%b busy=%b want 1 0 0 0",
               cmd_ready, op_ready, res_valid, busy);
    end
    checks++;
    if (res_data !== 32'h0 || mac_act !== 32'h0 || mac_wgt !== 32'h0 || mac_clr_n !== 1'b0) begin
      fails++;
      $display("FAIL reset_data got res=%h act=%h wgt=%h clr_n=%b want 0 0 0 0",
               res_data, mac_act, mac_wgt, mac_clr_n);
    end
    op_valid = 1'b0;
    reset    = 1'b0;
    tick();
    checks++;
    if (mac_clr_n !== 1'b1 || mac_acc !== 32'h0) begin
      fails++;
      $display("FAIL reset_exit got clr_n=%b acc=%h want 1 0", mac_clr_n, mac_acc);
    end
  endtask

  task automatic test_basic();
    int c, t, r;
    logic [31:0] ma, mw;
    do_cmd(16'd4, c);
    beat(32'h0403_0201, 32'hFE02_FF01, t, ma, mw);
    checks++;
    if (t - c !== 2) begin
      fails++;
      $display("FAIL basic_first_beat got %0d cycles want 2", t - c);
    end
    wait_res(r);
    checks++;
    if (r - t !== 2) begin
      fails++;
      $display("FAIL basic_latency got %0d cycles want 2", r - t);
    end
    checks++;
    if (res_data !== 32'hFFFF_FFFD || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_result got %h rdy=%b want fffffffd 0", res_data, cmd_ready);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_handshake got rv=%b rdy=%b busy=%b want 0 1 0",
               res_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_tail_mask();
    int c, t, r;
    logic [31:0] ma, mw;
    do_cmd(16'd6, c);
    beat(32'h0A0A_0A0A, 32'h0101_0101, t, ma, mw);
    beat(32'h6363_0505, 32'hF9F9_0202, t, ma, mw);
    checks++;
    if (ma !== 32'h0000_0505 || mw !== 32'h0000_0202) begin
      fails++;
      $display("FAIL tail_lanes got act=%h wgt=%h want 00000505 00000202", ma, mw);
    end
    #1;
    checks++;
    if (op_ready !== 1'b0) begin
      fails++;
      $display("FAIL tail_no_over_accept got op_ready=%b want 0", op_ready);
    end
    wait_res(r);
    checks++;
    if (res_data !== 32'h0000_003C) begin
      fails++;
      $display("FAIL tail_result got %h want 0000003c", res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_zero_len();
    int c, r;
    logic seen;
    seen = 1'b0;
    r = -1;
    op_valid = 1'b1;
    op_act   = 32'h0101_0101;
    op_wgt   = 32'h0101_0101;
    do_cmd(16'd0, c);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (op_ready || mac_act !== 32'h0) seen = 1'b1;
      if (res_valid) begin
        r = cyc;
        break;
      end
      tick();
    end
    op_valid = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL zero_no_beat got op_ready/lanes active want idle");
    end
    checks++;
    if (r - c !== 3) begin
      fails++;
      $display("FAIL zero_latency got %0d cycles want 3", r - c);
    end
    checks++;
    if (res_data !== 32'h0) begin
      fails++;
      $display("FAIL zero_result got %h want 00000000", res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_stall();
    int c, t, r;
    logic [31:0] ma, mw;
    logic gap_bad;
    gap_bad = 1'b0;
    do_cmd(16'd8, c);
    for (int b = 0; b < 2; b++) begin
      beat(32'hFFFF_FFFF, 32'h8080_8080, t, ma, mw);
      #1;
      if (mac_act !== 32'h0 || mac_wgt !== 32'h0) gap_bad = 1'b1;
      tick();
    end
    checks++;
    if (gap_bad !== 1'b0) begin
      fails++;
      $display("FAIL stall_gap_lanes got nonzero lanes in gap want zero");
    end
    wait_res(r);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== 32'hFFFC_0400) begin
        fails++;
        $display("FAIL stall_hold[%0d] got rv=%b data=%h want 1 fffc0400",
                 i, res_valid, res_data);
      end
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_abort();
    int c, t, r;
    logic [31:0] ma, mw;
    do_cmd(16'd12, c);
    beat(32'h0101_0101, 32'h7F7F_7F7F, t, ma, mw);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || op_ready !== 1'b0 || mac_clr_n !== 1'b0) begin
      fails++;
      $display("FAIL abort_state got busy=%b rdy=%b op=%b clr_n=%b want 0 1 0 0",
               busy, cmd_ready, op_ready, mac_clr_n);
    end
    tick();
    do_cmd(16'd4, c);
    beat(32'h0101_0101, 32'h0303_0303, t, ma, mw);
    wait_res(r);
    checks++;
    if (res_data !== 32'h0000_000C) begin
      fails++;
      $display("FAIL abort_result got %h want 0000000c", res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int c, t, r;
    logic [31:0] ma, mw;
    logic [31:0] wgts [2];
    logic [31:0] want [2];
    logic rdy_bad;
    wgts[0] = 32'h0201_0101;
    wgts[1] = 32'hFEFF_FFFF;
    want[0] = 32'h0000_0005;
    want[1] = 32'hFFFF_FFFB;
    res_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rdy_bad = 1'b0;
      do_cmd(16'd4, c);
      if (cmd_ready !== 1'b0) rdy_bad = 1'b1;
      beat(32'h0101_0101, wgts[k], t, ma, mw);
      for (int i = 0; i < 20; i++) begin
        #1;
        if (cmd_ready !== 1'b0) rdy_bad = 1'b1;
        if (res_valid) break;
        tick();
      end
      checks++;
      if (res_data !== want[k] || res_valid !== 1'b1) begin
        fails++;
        $display("FAIL b2b_result[%0d] got rv=%b data=%h want 1 %h",
                 k, res_valid, res_data, want[k]);
      end
      checks++;
      if (rdy_bad !== 1'b0) begin
        fails++;
        $display("FAIL b2b_cmd_ready[%0d] got cmd_ready high while busy want low", k);
      end
      tick();
      checks++;
      if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
        fails++;
        $display("FAIL b2b_release[%0d] got rdy=%b rv=%b want 1 0", k, cmd_ready, res_valid);
      end
    end
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tail_mask();
    test_zero_len();
    test_stall();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
